// File: rtl/opb_register_simulink2ppc_sync_if.sv
// OPB bus bundle between a PowerPC-side master and the simulink2ppc slave.
// The vectors use OPB big-endian numbering: bit 0 is the MSB.
`timescale 1ns/1ps
interface opb_register_simulink2ppc_sync_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc_sync.sv
// OPB slave exposing the newest fabric word to software, with NEW/OVERRUN flags,
// a 16-bit update counter and a read-acknowledge pulse back to the fabric.
`timescale 1ns/1ps
module opb_register_simulink2ppc_sync #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0300,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_03FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [55:0] C_FAMILY     = "virtex6"
) (
  input  logic                                 OPB_Clk,
  input  logic                                 OPB_Rst_n,
  opb_register_simulink2ppc_sync_if.slave      opb,
  input  logic [31:0]                          user_data_in,
  input  logic                                 user_data_valid,
  output logic                                 user_data_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [1:0] IDX_DATA   = 2'd0;
  localparam logic [1:0] IDX_STATUS = 2'd1;
  localparam logic [1:0] IDX_CTRL   = 2'd2;

  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        rst_int_n;

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        rnw_q, rnw_d;
  logic        clr_q, clr_d;
  logic [31:0] data_q, data_d;
  logic        new_q, new_d;
  logic        overrun_q, overrun_d;
  logic [15:0] count_q, count_d;
  logic        xfer_ack_q, xfer_ack_d;
  logic [31:0] dbus_q, dbus_d;
  logic        uack_q, uack_d;

  logic        hit_s;
  logic        rd_data_s;
  logic        ctrl_clr_s;
  logic        ovr_base_s;
  logic [15:0] cnt_base_s;
  logic [31:0] status_d_s;
  logic        unused_s;

  // Reset assertion is immediate; release reaches the core after two clock edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign hit_s = opb.OPB_select &&
                 (opb.OPB_ABus >= C_BASEADDR) && (opb.OPB_ABus <= C_HIGHADDR);

  assign rd_data_s  = (state_q == S_ACK) && rnw_q && (idx_q == IDX_DATA);
  assign ctrl_clr_s = (state_q == S_ACK) && !rnw_q && (idx_q == IDX_CTRL) && clr_q;
  assign ovr_base_s = ctrl_clr_s ? 1'b0 : overrun_q;
  assign cnt_base_s = ctrl_clr_s ? 16'd0 : count_q;

  // A CTRL clear lands before a same-cycle capture, so the capture counts as the first update.
  always_comb begin
    data_d    = data_q;
    new_d     = new_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    if (user_data_valid) begin
      data_d    = user_data_in;
      new_d     = 1'b1;
      count_d   = cnt_base_s + 16'd1;
      overrun_d = ovr_base_s | (new_q & ~rd_data_s & ~ctrl_clr_s);
    end else begin
      data_d    = data_q;
      new_d     = rd_data_s ? 1'b0 : new_q;
      count_d   = cnt_base_s;
      overrun_d = ovr_base_s;
    end
  end

  assign status_d_s = {count_d, 14'd0, overrun_d, new_d};

  // Read data is taken from the register values that will hold during the ACK cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rnw_d      = rnw_q;
    clr_d      = clr_q;
    xfer_ack_d = 1'b0;
    dbus_d     = 32'd0;
    uack_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit_s) begin
          state_d    = S_ACK;
          idx_d      = opb.OPB_ABus[28:29];
          rnw_d      = opb.OPB_RNW;
          clr_d      = opb.OPB_BE[3] & opb.OPB_DBus[31];
          xfer_ack_d = 1'b1;
          if (opb.OPB_RNW) begin
            case (opb.OPB_ABus[28:29])
              IDX_DATA:   dbus_d = data_d;
              IDX_STATUS: dbus_d = status_d_s;
              default:    dbus_d = 32'd0;
            endcase
            uack_d = (opb.OPB_ABus[28:29] == IDX_DATA);
          end else begin
            dbus_d = 32'd0;
            uack_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!opb.OPB_select) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      rnw_q      <= 1'b0;
      clr_q      <= 1'b0;
      data_q     <= 32'd0;
      new_q      <= 1'b0;
      overrun_q  <= 1'b0;
      count_q    <= 16'd0;
      xfer_ack_q <= 1'b0;
      dbus_q     <= 32'd0;
      uack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rnw_q      <= rnw_d;
      clr_q      <= clr_d;
      data_q     <= data_d;
      new_q      <= new_d;
      overrun_q  <= overrun_d;
      count_q    <= count_d;
      xfer_ack_q <= xfer_ack_d;
      dbus_q     <= dbus_d;
      uack_q     <= uack_d;
    end
  end

  assign opb.Sl_DBus    = dbus_q;
  assign opb.Sl_xferAck = xfer_ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign user_data_ack  = uack_q;

  assign unused_s = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], opb.OPB_DBus[0:30],
                      ^C_FAMILY, C_OPB_AWIDTH[0], C_OPB_DWIDTH[0]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_sync.sv
// Scenario-per-task bench for opb_register_simulink2ppc_sync with a queue of expected read data.
`timescale 1ns/1ps
module tb_opb_register_simulink2ppc_sync;

  localparam logic [31:0] A_DATA   = 32'h0100_0300;
  localparam logic [31:0] A_STATUS = 32'h0100_0304;
  localparam logic [31:0] A_CTRL   = 32'h0100_0308;
  localparam logic [31:0] A_RSVD   = 32'h0100_030C;

  logic        clk;
  logic        rst_n;
  logic [31:0] user_data_in;
  logic        user_data_valid;
  logic        user_data_ack;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  opb_register_simulink2ppc_sync_if opb_bus ();

  opb_register_simulink2ppc_sync dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .opb             (opb_bus.slave),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid),
    .user_data_ack   (user_data_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                         input bit v_in_ack, input logic [31:0] vdata,
                         output logic [31:0] rd, output bit acked, output int lat,
                         output logic ua, output realtime t_ack);
    repeat (2) @(negedge clk);
    opb_bus.OPB_ABus   = addr;
    opb_bus.OPB_RNW    = rnw;
    opb_bus.OPB_DBus   = wdata;
    opb_bus.OPB_BE     = 4'hF;
    opb_bus.OPB_select = 1'b1;
    acked = 1'b0; lat = 0; rd = 32'd0; ua = 1'b0; t_ack = 0.0;
    for (int i = 1; i <= 8 && !acked; i++) begin
      @(negedge clk);
      if (opb_bus.Sl_xferAck) begin
        acked = 1'b1;
        lat   = i;
        rd    = opb_bus.Sl_DBus;
        ua    = user_data_ack;
        t_ack = $realtime;
        opb_bus.OPB_select = 1'b0;
        if (v_in_ack) begin
          user_data_valid = 1'b1;
          user_data_in    = vdata;
        end
      end
    end
    opb_bus.OPB_select = 1'b0;
    if (v_in_ack && acked) begin
      @(negedge clk);
      user_data_valid = 1'b0;
    end
  endtask

  task automatic pulse_valid(input logic [31:0] v);
    @(negedge clk);
    user_data_in    = v;
    user_data_valid = 1'b1;
    @(negedge clk);
    user_data_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] expv);
    logic [31:0] rd, exp;
    bit acked; int lat; logic ua; realtime t;
    exp_q.push_back(expv);
    do_xfer(addr, 1'b1, 32'd0, 1'b0, 32'd0, rd, acked, lat, ua, t);
    exp = exp_q.pop_front();
    n_total++;
    if (!acked || rd !== exp)
      $display("FAIL %s: got %h (ack=%0d), expected %h", name, rd, acked, exp);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp;
    bit acked; int lat; logic ua; realtime t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (opb_bus.Sl_xferAck !== 1'b0 || opb_bus.Sl_DBus !== 32'd0 || user_data_ack !== 1'b0)
      $display("FAIL reset_outputs: got ack=%b dbus=%h uack=%b, expected 0/0/0",
               opb_bus.Sl_xferAck, opb_bus.Sl_DBus, user_data_ack);
    else
      n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h0000_0000);
    do_xfer(A_STATUS, 1'b1, 32'd0, 1'b0, 32'd0, rd, acked, lat, ua, t);
    exp = exp_q.pop_front();
    n_total++;
    if (!acked || rd !== exp)
      $display("FAIL reset_status: got %h (ack=%0d), expected %h", rd, acked, exp);
    else
      n_pass++;
    n_total++;
    if (lat !== 1)
      $display("FAIL ack_latency: got %0d, expected 1", lat);
    else
      n_pass++;
  endtask

  task automatic test_capture();
    logic [31:0] rd, exp;
    bit acked; int lat; logic ua; realtime t;
    pulse_valid(32'hDEAD_BEEF);
    read_check("capture_status", A_STATUS, 32'h0001_0001);
    exp_q.push_back(32'hDEAD_BEEF);
    do_xfer(A_DATA, 1'b1, 32'd0, 1'b0, 32'd0, rd, acked, lat, ua, t);
    exp = exp_q.pop_front();
    n_total++;
    if (!acked || rd !== exp)
      $display("FAIL capture_data: got %h (ack=%0d), expected %h", rd, acked, exp);
    else
      n_pass++;
    n_total++;
    if (ua !== 1'b1)
      $display("FAIL uack_pulse: got %b, expected 1", ua);
    else
      n_pass++;
    @(negedge clk);
    n_total++;
    if (user_data_ack !== 1'b0)
      $display("FAIL uack_single: got %b, expected 0", user_data_ack);
    else
      n_pass++;
    read_check("reread_status", A_STATUS, 32'h0001_0000);
  endtask

  task automatic test_overrun_clear();
    logic [31:0] rd;
    bit acked; int lat; logic ua; realtime t;
    do_xfer(A_CTRL, 1'b0, 32'h0000_0001, 1'b0, 32'd0, rd, acked, lat, ua, t);
    pulse_valid(32'h0000_0001);
    pulse_valid(32'h0000_0002);
    read_check("overrun_status", A_STATUS, 32'h0002_0003);
    do_xfer(A_CTRL, 1'b0, 32'h0000_0001, 1'b0, 32'd0, rd, acked, lat, ua, t);
    n_total++;
    if (!acked)
      $display("FAIL ctrl_write_ack: got 0, expected 1");
    else
      n_pass++;
    read_check("cleared_status", A_STATUS, 32'h0000_0001);
    read_check("overrun_data", A_DATA, 32'h0000_0002);
    read_check("after_data_status", A_STATUS, 32'h0000_0000);
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd, exp;
    bit acked; int lat; logic ua; realtime t;
    pulse_valid(32'h0000_0044);
    exp_q.push_back(32'h0000_0044);
    do_xfer(A_DATA, 1'b1, 32'd0, 1'b1, 32'h0000_0055, rd, acked, lat, ua, t);
    exp = exp_q.pop_front();
    n_total++;
    if (!acked || rd !== exp)
      $display("FAIL simul_old_word: got %h (ack=%0d), expected %h", rd, acked, exp);
    else
      n_pass++;
    read_check("simul_status", A_STATUS, 32'h0002_0001);
    read_check("simul_new_word", A_DATA, 32'h0000_0055);
  endtask

  task automatic test_clear_with_valid();
    logic [31:0] rd;
    bit acked; int lat; logic ua; realtime t;
    pulse_valid(32'h0000_000A);
    pulse_valid(32'h0000_000B);
    read_check("pre_clear_status", A_STATUS, 32'h0004_0003);
    do_xfer(A_CTRL, 1'b0, 32'h0000_0001, 1'b1, 32'h0000_000C, rd, acked, lat, ua, t);
    read_check("clear_valid_status", A_STATUS, 32'h0001_0001);
    read_check("clear_valid_data", A_DATA, 32'h0000_000C);
  endtask

  task automatic test_hold_select();
    int acks = 0;
    repeat (2) @(negedge clk);
    opb_bus.OPB_ABus   = A_DATA;
    opb_bus.OPB_RNW    = 1'b1;
    opb_bus.OPB_select = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (opb_bus.Sl_xferAck) acks++;
    end
    opb_bus.OPB_select = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (opb_bus.Sl_xferAck) acks++;
    end
    n_total++;
    if (acks !== 1)
      $display("FAIL hold_select_acks: got %0d, expected 1", acks);
    else
      n_pass++;
  endtask

  task automatic test_miss();
    logic [31:0] rd, addrs[2];
    bit acked; int lat; logic ua; realtime t;
    int bad;
    addrs[0] = 32'h0100_0400;
    addrs[1] = 32'h0100_02FC;
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      @(negedge clk);
      opb_bus.OPB_ABus   = addrs[k];
      opb_bus.OPB_RNW    = 1'b1;
      opb_bus.OPB_select = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (opb_bus.Sl_xferAck !== 1'b0 || opb_bus.Sl_DBus !== 32'd0) bad++;
      end
      opb_bus.OPB_select = 1'b0;
      n_total++;
      if (bad !== 0)
        $display("FAIL miss_no_response: addr %h got %0d bad cycles, expected 0", addrs[k], bad);
      else
        n_pass++;
    end
    do_xfer(A_RSVD, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'd0, rd, acked, lat, ua, t);
    do_xfer(A_STATUS, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'd0, rd, acked, lat, ua, t);
    n_total++;
    if (!acked)
      $display("FAIL ro_write_ack: got 0, expected 1");
    else
      n_pass++;
    read_check("rsvd_read", A_RSVD, 32'h0000_0000);
    read_check("ctrl_read", A_CTRL, 32'h0000_0000);
    read_check("ignored_writes_status", A_STATUS, 32'h0001_0000);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bit acked; int lat; logic ua;
    realtime t0, t1;
    do_xfer(A_STATUS, 1'b1, 32'd0, 1'b0, 32'd0, rd, acked, lat, ua, t0);
    do_xfer(A_STATUS, 1'b1, 32'd0, 1'b0, 32'd0, rd, acked, lat, ua, t1);
    n_total++;
    if (!acked || (t1 - t0) != 30.0)
      $display("FAIL back_to_back_period: got %0t ns (ack=%0d), expected 30 ns", t1 - t0, acked);
    else
      n_pass++;
  endtask

  task automatic test_reset_in_ack();
    int acks = 0;
    int bad  = 0;
    repeat (2) @(negedge clk);
    opb_bus.OPB_ABus   = A_STATUS;
    opb_bus.OPB_RNW    = 1'b1;
    opb_bus.OPB_select = 1'b1;
    #3;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (opb_bus.Sl_xferAck) acks++;
      if (opb_bus.Sl_DBus !== 32'd0 || user_data_ack !== 1'b0) bad++;
    end
    opb_bus.OPB_select = 1'b0;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (opb_bus.Sl_xferAck) acks++;
    end
    n_total++;
    if (acks !== 0 || bad !== 0)
      $display("FAIL reset_abandon: got %0d acks %0d bad cycles, expected 0/0", acks, bad);
    else
      n_pass++;
    read_check("post_reset_status", A_STATUS, 32'h0000_0000);
    read_check("post_reset_data", A_DATA, 32'h0000_0000);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    user_data_in    = 32'hA5A5_0000;
    user_data_valid = 1'b1;
    repeat (65535) @(negedge clk);
    user_data_valid = 1'b0;
    read_check("count_ffff", A_STATUS, 32'hFFFF_0003);
    pulse_valid(32'h1234_5678);
    read_check("count_wrap", A_STATUS, 32'h0000_0003);
    read_check("wrap_data", A_DATA, 32'h1234_5678);
  endtask

  initial begin
    rst_n               = 1'b0;
    user_data_in        = 32'd0;
    user_data_valid     = 1'b0;
    opb_bus.OPB_ABus    = 32'd0;
    opb_bus.OPB_BE      = 4'h0;
    opb_bus.OPB_DBus    = 32'd0;
    opb_bus.OPB_RNW     = 1'b0;
    opb_bus.OPB_select  = 1'b0;
    opb_bus.OPB_seqAddr = 1'b0;
    test_reset();
    test_capture();
    test_overrun_clear();
    test_simultaneous();
    test_clear_with_valid();
    test_hold_select();
    test_miss();
    test_back_to_back();
    test_reset_in_ack();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
